// File: rtl/l2_access_controller.sv
// L2 access controller: sequences one line-granular request at a time
// through tag lookup, hit/miss resolution, optional victim writeback,
// bus fill/upgrade, array update (tag/MESI/LRU touch) and a response pulse.
// All outputs are registered and decoded from the next FSM state.
module l2_access_controller #(
    parameter int indexBits = 14,
    parameter int tagBits   = 12,
    parameter int ways      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [tagBits+indexBits-1:0]   req_addr,
    output logic                           rsp_valid,
    output logic                           rsp_hit,
    output logic                           arr_en,
    output logic                           arr_we,
    output logic [indexBits-1:0]           arr_index,
    output logic [$clog2(ways)-1:0]        arr_way,
    output logic [tagBits-1:0]             arr_tag,
    output logic [3:0]                     arr_mesi,
    input  logic                           arr_hit,
    input  logic [$clog2(ways)-1:0]        arr_hit_way,
    input  logic [3:0]                     arr_hit_mesi,
    input  logic [$clog2(ways)-1:0]        arr_victim_way,
    input  logic [tagBits-1:0]             arr_victim_tag,
    input  logic [3:0]                     arr_victim_mesi,
    output logic                           bus_req,
    output logic [1:0]                     bus_cmd,
    output logic [tagBits+indexBits-1:0]   bus_addr,
    input  logic                           bus_gnt,
    input  logic                           bus_done,
    input  logic                           bus_shared
);

    localparam int wayBits  = $clog2(ways);
    localparam int addrBits = tagBits + indexBits;

    localparam logic [3:0] MESI_M = 4'b1000;
    localparam logic [3:0] MESI_E = 4'b0100;
    localparam logic [3:0] MESI_S = 4'b0010;

    localparam logic [1:0] CMD_READ = 2'd0;
    localparam logic [1:0] CMD_RFO  = 2'd1;
    localparam logic [1:0] CMD_WB   = 2'd2;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOOKUP   = 4'd1,
        CHECK    = 4'd2,
        WB_REQ   = 4'd3,
        WB_WAIT  = 4'd4,
        BUS_REQ  = 4'd5,
        BUS_WAIT = 4'd6,
        UPDATE   = 4'd7,
        RESP     = 4'd8
    } state_t;

    state_t                state_r, state_next_s;
    logic [addrBits-1:0]   addr_r;
    logic                  write_r;
    logic [wayBits-1:0]    way_r, way_next_s;
    logic [3:0]            mesi_r, mesi_next_s;
    logic                  hit_r, hit_next_s;
    logic [1:0]            cmd_r, cmd_next_s;
    logic [3:0]            fill_mesi_s;

    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic                  rsp_hit_r;
    logic                  arr_en_r;
    logic                  arr_we_r;
    logic [indexBits-1:0]  arr_index_r;
    logic [wayBits-1:0]    arr_way_r;
    logic [tagBits-1:0]    arr_tag_r;
    logic [3:0]            arr_mesi_r;
    logic                  bus_req_r;
    logic [1:0]            bus_cmd_r;
    logic [addrBits-1:0]   bus_addr_r;

    // Next-state, way/MESI/hit/command decisions for the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        way_next_s   = way_r;
        mesi_next_s  = mesi_r;
        hit_next_s   = hit_r;
        cmd_next_s   = cmd_r;
        // Fill state: reads become E unless another cache shares the line.
        if (write_r) begin
            fill_mesi_s = MESI_M;
        end else if (bus_shared) begin
            fill_mesi_s = MESI_S;
        end else begin
            fill_mesi_s = MESI_E;
        end
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = LOOKUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOOKUP: state_next_s = CHECK;
            CHECK: begin
                if (arr_hit) begin
                    way_next_s = arr_hit_way;
                    if (!write_r) begin
                        mesi_next_s  = arr_hit_mesi;
                        hit_next_s   = 1'b1;
                        state_next_s = UPDATE;
                    end else if ((arr_hit_mesi == MESI_M) || (arr_hit_mesi == MESI_E)) begin
                        mesi_next_s  = MESI_M;
                        hit_next_s   = 1'b1;
                        state_next_s = UPDATE;
                    end else begin
                        // Write to a shared line: upgrade in place, no victim.
                        hit_next_s   = 1'b0;
                        cmd_next_s   = CMD_RFO;
                        state_next_s = BUS_REQ;
                    end
                end else begin
                    way_next_s = arr_victim_way;
                    hit_next_s = 1'b0;
                    cmd_next_s = write_r ? CMD_RFO : CMD_READ;
                    if (arr_victim_mesi == MESI_M) begin
                        state_next_s = WB_REQ;
                    end else begin
                        state_next_s = BUS_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (bus_gnt && bus_done) begin
                    state_next_s = BUS_REQ;
                end else if (bus_gnt) begin
                    state_next_s = WB_WAIT;
                end else begin
                    state_next_s = WB_REQ;
                end
            end
            WB_WAIT: begin
                if (bus_done) begin
                    state_next_s = BUS_REQ;
                end else begin
                    state_next_s = WB_WAIT;
                end
            end
            BUS_REQ: begin
                if (bus_gnt && bus_done) begin
                    mesi_next_s  = fill_mesi_s;
                    state_next_s = UPDATE;
                end else if (bus_gnt) begin
                    state_next_s = BUS_WAIT;
                end else begin
                    state_next_s = BUS_REQ;
                end
            end
            BUS_WAIT: begin
                if (bus_done) begin
                    mesi_next_s  = fill_mesi_s;
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = BUS_WAIT;
                end
            end
            UPDATE:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state and per-transaction context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= '0;
            write_r <= 1'b0;
            way_r   <= '0;
            mesi_r  <= 4'b0000;
            hit_r   <= 1'b0;
            cmd_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            way_r   <= way_next_s;
            mesi_r  <= mesi_next_s;
            hit_r   <= hit_next_s;
            cmd_r   <= cmd_next_s;
            if ((state_r == IDLE) && req_valid) begin
                addr_r  <= req_addr;
                write_r <= req_write;
            end
        end
    end

    // Registered outputs decoded from the state being entered; data fields
    // load only on entry to the state that uses them and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            arr_en_r    <= 1'b0;
            arr_we_r    <= 1'b0;
            arr_index_r <= '0;
            arr_way_r   <= '0;
            arr_tag_r   <= '0;
            arr_mesi_r  <= 4'b0000;
            bus_req_r   <= 1'b0;
            bus_cmd_r   <= 2'd0;
            bus_addr_r  <= '0;
        end else begin
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == RESP);
            rsp_hit_r   <= (state_next_s == RESP) ? hit_next_s : 1'b0;
            arr_en_r    <= (state_next_s == LOOKUP) || (state_next_s == UPDATE);
            arr_we_r    <= (state_next_s == UPDATE);
            bus_req_r   <= (state_next_s == WB_REQ) || (state_next_s == BUS_REQ);
            if (state_next_s == LOOKUP) begin
                arr_index_r <= req_addr[indexBits-1:0];
            end
            if (state_next_s == UPDATE) begin
                arr_way_r  <= way_next_s;
                arr_tag_r  <= addr_r[addrBits-1:indexBits];
                arr_mesi_r <= mesi_next_s;
            end
            if ((state_next_s == WB_REQ) && (state_r != WB_REQ)) begin
                bus_cmd_r  <= CMD_WB;
                bus_addr_r <= {arr_victim_tag, addr_r[indexBits-1:0]};
            end
            if ((state_next_s == BUS_REQ) && (state_r != BUS_REQ)) begin
                bus_cmd_r  <= cmd_next_s;
                bus_addr_r <= addr_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_hit   = rsp_hit_r;
    assign arr_en    = arr_en_r;
    assign arr_we    = arr_we_r;
    assign arr_index = arr_index_r;
    assign arr_way   = arr_way_r;
    assign arr_tag   = arr_tag_r;
    assign arr_mesi  = arr_mesi_r;
    assign bus_req   = bus_req_r;
    assign bus_cmd   = bus_cmd_r;
    assign bus_addr  = bus_addr_r;

endmodule

// File: tb/tb_l2_access_controller.sv
// Directed, table-driven bench for l2_access_controller with an inline
// array/bus responder, plus hand-written reset and back-pressure sequences.
module tb_l2_access_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [25:0] req_addr = 26'd0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        arr_en;
    logic        arr_we;
    logic [13:0] arr_index;
    logic [2:0]  arr_way;
    logic [11:0] arr_tag;
    logic [3:0]  arr_mesi;
    logic        arr_hit = 1'b0;
    logic [2:0]  arr_hit_way = 3'd0;
    logic [3:0]  arr_hit_mesi = 4'b0001;
    logic [2:0]  arr_victim_way = 3'd0;
    logic [11:0] arr_victim_tag = 12'd0;
    logic [3:0]  arr_victim_mesi = 4'b0001;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [25:0] bus_addr;
    logic        bus_gnt = 1'b0;
    logic        bus_done = 1'b0;
    logic        bus_shared = 1'b0;

    int total_cnt = 0;
    int pass_cnt  = 0;

    localparam logic [3:0] M = 4'b1000;
    localparam logic [3:0] E = 4'b0100;
    localparam logic [3:0] S = 4'b0010;
    localparam logic [3:0] I = 4'b0001;

    l2_access_controller #(.indexBits(14), .tagBits(12), .ways(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .arr_en(arr_en), .arr_we(arr_we), .arr_index(arr_index), .arr_way(arr_way),
        .arr_tag(arr_tag), .arr_mesi(arr_mesi),
        .arr_hit(arr_hit), .arr_hit_way(arr_hit_way), .arr_hit_mesi(arr_hit_mesi),
        .arr_victim_way(arr_victim_way), .arr_victim_tag(arr_victim_tag), .arr_victim_mesi(arr_victim_mesi),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_gnt(bus_gnt), .bus_done(bus_done), .bus_shared(bus_shared)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [25:0] addr;
        logic        hit;
        logic [2:0]  hway;
        logic [3:0]  hmesi;
        logic [2:0]  vway;
        logic [11:0] vtag;
        logic [3:0]  vmesi;
        logic        shared;
        int          g;      // cycles bus_req waits before grant
        int          d;      // cycles from grant to done (0 = same cycle)
        logic        ehit;
        logic [2:0]  eway;
        logic [3:0]  emesi;
        int          ncmd;
        logic [1:0]  cmd0;
        logic [25:0] a0;
        logic [1:0]  cmd1;
        logic [25:0] a1;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc = 0, req_hi = 0, done_cnt = 0, ngnt = 0, nupd = 0, lat = -1;
        logic [1:0]  cmds[2];
        logic [25:0] addrs[2];
        logic drop_chk = 1'b0, drop_bad = 1'b0, fin = 1'b0, got_hit = 1'b0;
        logic [2:0]  uw = 3'd0;
        logic [11:0] ut = 12'd0;
        logic [3:0]  um = 4'd0;
        logic [13:0] lidx = 14'd0;
        cmds[0] = 2'd3; cmds[1] = 2'd3; addrs[0] = 26'd0; addrs[1] = 26'd0;
        arr_hit = v.hit; arr_hit_way = v.hway; arr_hit_mesi = v.hmesi;
        arr_victim_way = v.vway; arr_victim_tag = v.vtag; arr_victim_mesi = v.vmesi;
        @(negedge clk);
        chk($sformatf("v%0d_ready", id), {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            bus_gnt = 1'b0; bus_done = 1'b0; bus_shared = 1'b0;
            if (drop_chk) begin
                if (bus_req) drop_bad = 1'b1;
                drop_chk = 1'b0;
            end
            if (arr_en && !arr_we) lidx = arr_index;
            if (arr_en && arr_we) begin
                nupd++; uw = arr_way; ut = arr_tag; um = arr_mesi;
            end
            if (rsp_valid) begin
                fin = 1'b1; lat = cyc; got_hit = rsp_hit;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    bus_done = 1'b1; bus_shared = v.shared;
                end
            end else if (bus_req) begin
                if (req_hi == v.g) begin
                    bus_gnt = 1'b1;
                    if (ngnt < 2) begin
                        cmds[ngnt] = bus_cmd; addrs[ngnt] = bus_addr;
                    end
                    ngnt++;
                    req_hi = 0;
                    if (v.d == 0) begin
                        bus_done = 1'b1; bus_shared = v.shared;
                    end else begin
                        done_cnt = v.d; drop_chk = 1'b1;
                    end
                end else begin
                    req_hi++;
                end
            end
        end
        bus_gnt = 1'b0; bus_done = 1'b0; bus_shared = 1'b0;
        chk($sformatf("v%0d_finished", id), {63'd0, fin}, 64'd1);
        chk($sformatf("v%0d_latency", id), lat, v.lat);
        chk($sformatf("v%0d_rsp_hit", id), {63'd0, got_hit}, {63'd0, v.ehit});
        chk($sformatf("v%0d_lookup_idx", id), lidx, v.addr[13:0]);
        chk($sformatf("v%0d_upd_count", id), nupd, 1);
        chk($sformatf("v%0d_upd_way", id), uw, v.eway);
        chk($sformatf("v%0d_upd_tag", id), ut, v.addr[25:14]);
        chk($sformatf("v%0d_upd_mesi", id), um, v.emesi);
        chk($sformatf("v%0d_bus_txns", id), ngnt, v.ncmd);
        chk($sformatf("v%0d_bus_drop", id), {63'd0, drop_bad}, 64'd0);
        if (v.ncmd >= 1) begin
            chk($sformatf("v%0d_cmd0", id), {cmds[0], addrs[0]}, {v.cmd0, v.a0});
        end
        if (v.ncmd >= 2) begin
            chk($sformatf("v%0d_cmd1", id), {cmds[1], addrs[1]}, {v.cmd1, v.a1});
        end
        @(negedge clk);
        chk($sformatf("v%0d_rsp_one_cycle", id), {62'd0, rsp_valid, req_ready}, 64'd1);
    endtask

    initial begin : main
        int acc, acc2, nrsp, nwe, waitc;
        //            wr    addr                   hit hway hmesi vway vtag     vmesi sh  g   d  ehit eway emesi ncmd cmd0  a0                      cmd1  a1                     lat
        vecs[0]  = '{1'b0, {12'h123, 14'h0456}, 1'b1, 3'd3, E, 3'd5, 12'h000, S, 1'b0, 0, 1, 1'b1, 3'd3, E, 0, 2'd0, 26'd0,                 2'd0, 26'd0,                4};
        vecs[1]  = '{1'b0, {12'h2A1, 14'h1111}, 1'b0, 3'd0, I, 3'd5, 12'h777, S, 1'b0, 0, 1, 1'b0, 3'd5, E, 1, 2'd0, {12'h2A1, 14'h1111}, 2'd0, 26'd0,                6};
        vecs[2]  = '{1'b0, {12'h3FF, 14'h3FFF}, 1'b0, 3'd0, I, 3'd1, 12'h010, E, 1'b1, 0, 2, 1'b0, 3'd1, S, 1, 2'd0, {12'h3FF, 14'h3FFF}, 2'd0, 26'd0,                7};
        vecs[3]  = '{1'b1, {12'h456, 14'h0123}, 1'b0, 3'd0, I, 3'd6, 12'hABC, M, 1'b0, 0, 1, 1'b0, 3'd6, M, 2, 2'd2, {12'hABC, 14'h0123}, 2'd1, {12'h456, 14'h0123}, 8};
        vecs[4]  = '{1'b1, {12'h0F0, 14'h2000}, 1'b1, 3'd2, S, 3'd4, 12'h000, E, 1'b0, 0, 1, 1'b0, 3'd2, M, 1, 2'd1, {12'h0F0, 14'h2000}, 2'd0, 26'd0,                6};
        vecs[5]  = '{1'b1, {12'h0F0, 14'h2001}, 1'b1, 3'd7, E, 3'd4, 12'h000, M, 1'b0, 0, 1, 1'b1, 3'd7, M, 0, 2'd0, 26'd0,                 2'd0, 26'd0,                4};
        vecs[6]  = '{1'b1, {12'h001, 14'h0000}, 1'b1, 3'd0, M, 3'd4, 12'h000, M, 1'b0, 0, 1, 1'b1, 3'd0, M, 0, 2'd0, 26'd0,                 2'd0, 26'd0,                4};
        vecs[7]  = '{1'b0, {12'h555, 14'h1555}, 1'b0, 3'd0, I, 3'd2, 12'h000, I, 1'b0, 0, 0, 1'b0, 3'd2, E, 1, 2'd0, {12'h555, 14'h1555}, 2'd0, 26'd0,                5};
        vecs[8]  = '{1'b1, {12'h800, 14'h0001}, 1'b0, 3'd0, I, 3'd4, 12'h123, S, 1'b0, 10, 1, 1'b0, 3'd4, M, 1, 2'd1, {12'h800, 14'h0001}, 2'd0, 26'd0,               16};
        vecs[9]  = '{1'b1, {12'h00A, 14'h0002}, 1'b0, 3'd0, I, 3'd7, 12'hFFF, M, 1'b0, 0, 0, 1'b0, 3'd7, M, 2, 2'd2, {12'hFFF, 14'h0002}, 2'd1, {12'h00A, 14'h0002}, 6};
        vecs[10] = '{1'b0, {12'h111, 14'h0300}, 1'b0, 3'd0, I, 3'd0, 12'h5A5, M, 1'b1, 2, 3, 1'b0, 3'd0, S, 2, 2'd2, {12'h5A5, 14'h0300}, 2'd0, {12'h111, 14'h0300}, 16};
        vecs[11] = '{1'b0, {12'h222, 14'h0010}, 1'b1, 3'd4, S, 3'd1, 12'h000, E, 1'b0, 0, 1, 1'b1, 3'd4, S, 0, 2'd0, 26'd0,                 2'd0, 26'd0,                4};
        vecs[12] = '{1'b0, {12'h333, 14'h0020}, 1'b1, 3'd6, M, 3'd1, 12'h000, E, 1'b0, 0, 1, 1'b1, 3'd6, M, 0, 2'd0, 26'd0,                 2'd0, 26'd0,                4};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {58'd0, req_ready, rsp_valid, rsp_hit, arr_en, arr_we, bus_req}, 64'h20);
        chk("reset_data", {arr_index, arr_way, arr_tag, arr_mesi, bus_cmd}, 64'd0);
        chk("reset_bus_addr", bus_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            run_vec(vecs[k], k);
        end

        // Reset in BUS_WAIT aborts the transaction.
        @(negedge clk);
        arr_hit = 1'b0; arr_victim_way = 3'd3; arr_victim_tag = 12'h0; arr_victim_mesi = S;
        req_valid = 1'b1; req_write = 1'b1; req_addr = {12'h777, 14'h0777};
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (!bus_req && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("rst_seq_bus_req_seen", {63'd0, bus_req}, 64'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seq_in_wait", {62'd0, bus_req, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_seq_abort", {60'd0, bus_req, req_ready, rsp_valid, arr_en}, 64'h4);
        @(negedge clk);
        rst_n = 1'b1;
        bus_done = 1'b1;
        nrsp = 0; nwe = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus_done = 1'b0;
            if (rsp_valid) nrsp++;
            if (arr_en && arr_we) nwe++;
        end
        chk("rst_seq_no_rsp", nrsp, 0);
        chk("rst_seq_no_update", nwe, 0);
        chk("rst_seq_idle", {62'd0, req_ready, bus_req}, 64'h2);

        // req_valid held while busy: accepted once, next acceptance after RESP.
        @(negedge clk);
        arr_hit = 1'b1; arr_hit_way = 3'd1; arr_hit_mesi = E;
        req_valid = 1'b1; req_write = 1'b0; req_addr = {12'h0AA, 14'h00AA};
        acc = 0; acc2 = -1; nrsp = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) acc2 = c;
            end else if (acc >= 2) begin
                req_valid = 1'b0;
            end
            if (rsp_valid) nrsp++;
        end
        req_valid = 1'b0;
        chk("bp_accept_count", acc, 2);
        chk("bp_second_accept_cycle", acc2, 5);
        chk("bp_rsp_count", nrsp, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/l2_access_controller.md
Name: l2_access_controller

Overview:
- Sequencing FSM in front of the L2 tag/data/MESI/LRU storage array.
- Accepts one line-granular read or write request at a time and performs the tag lookup.
- Resolves hit/miss, writes back Modified victims and fills or upgrades over the shared bus.
- Writes the new tag/MESI and LRU touch into the array, then returns a one-cycle response.

Parameters:
- indexBits, 14, set index width.
- tagBits, 12, tag width.
- ways, 8, associativity; way fields are $clog2(ways) bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  tagBits+indexBits  line address, {tag,index}.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_hit  out  1  request hit with sufficient permission.
- arr_en  out  1  array access strobe.
- arr_we  out  1  1=update tag/MESI/LRU, 0=lookup.
- arr_index  out  indexBits  set index.
- arr_way  out  $clog2(ways)  way to update.
- arr_tag  out  tagBits  tag to write.
- arr_mesi  out  4  MESI to write, one-hot: M=1000, E=0100, S=0010, I=0001.
- arr_hit  in  1  lookup result: valid tag match; valid the cycle after a lookup strobe.
- arr_hit_way  in  $clog2(ways)  matching way.
- arr_hit_mesi  in  4  MESI of matching way.
- arr_victim_way  in  $clog2(ways)  LRU victim way.
- arr_victim_tag  in  tagBits  victim tag.
- arr_victim_mesi  in  4  victim MESI.
- bus_req  out  1  shared-bus request.
- bus_cmd  out  2  0=READ, 1=RFO, 2=WRITEBACK.
- bus_addr  out  tagBits+indexBits  bus line address.
- bus_gnt  in  1  bus granted.
- bus_done  in  1  transaction complete.
- bus_shared  in  1  another cache holds the line; sampled with bus_done.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE.
- Reset asserted mid-transaction aborts the transaction immediately: bus_req drops; no array write or response is issued.
- Request latching: IDLE with req_valid -> latch addr/write, go LOOKUP; req_ready=1 only in IDLE.
- LOOKUP (1 cycle): arr_en=1, arr_we=0, arr_index=latched index -> CHECK.
- CHECK samples array outputs:
  - Read hit: way=hit_way, mesi=hit_mesi, rsp_hit=1 -> UPDATE.
  - Write hit, M or E: way=hit_way, mesi=M, rsp_hit=1 -> UPDATE.
  - Write hit, S: way=hit_way, rsp_hit=0, cmd=RFO -> BUS_REQ (upgrade; no writeback).
  - Miss: way=victim_way, rsp_hit=0. Victim M -> WB_REQ. Otherwise -> BUS_REQ with cmd READ (read) or RFO (write).
- WB_REQ: bus_req=1, bus_cmd=2, bus_addr={victim_tag,index}.
  - bus_gnt -> WB_WAIT.
  - bus_gnt and bus_done in the same cycle -> BUS_REQ directly.
- WB_WAIT: bus_req=0; bus_done -> BUS_REQ.
- BUS_REQ: bus_req=1, bus_cmd=READ/RFO, bus_addr=latched addr.
  - bus_gnt -> BUS_WAIT.
  - bus_gnt and bus_done in the same cycle: treat as done.
- BUS_WAIT: on bus_done, capture mesi: read -> S if bus_shared else E; write -> M. Then -> UPDATE.
- bus_req stays high until bus_gnt; it drops the cycle after grant.
- UPDATE (1 cycle): arr_en=1, arr_we=1, arr_way, arr_tag=latched tag, arr_mesi=captured -> RESP.
  - A read hit rewrites identical MESI; that write is the LRU touch.
- RESP: rsp_valid=1 for one cycle, rsp_hit held -> IDLE.
- Latency from acceptance edge to rsp_valid: hit = 4 cycles; miss = 4 + bus cycles.
- Request traffic: req_valid while busy is ignored, and no request is lost because req_ready=0. A new request can be accepted the cycle after RESP.
- arr_* outputs other than arr_en/arr_we hold their last value and are don't-care when arr_en=0. bus_addr/bus_cmd are don't-care when bus_req=0.

Test Plan:
1. Read hit: array returns hit=1, way 3, mesi E -> UPDATE writes way 3 with E; rsp_valid 4 cycles after acceptance, rsp_hit=1; no bus_req.
2. Read miss, clean victim: hit=0, victim way 5, mesi S; bus_shared=0 at done -> bus_cmd=0 at req addr; UPDATE writes way 5, tag=req tag, mesi 0100; rsp_hit=0.
3. Write miss, dirty victim: victim mesi 1000, tag 0xABC -> WRITEBACK to {0xABC,index} first, then RFO; UPDATE mesi 1000.
4. Write hit on S: RFO upgrade on hit way, no writeback, final mesi M, rsp_hit=0. Repeat with the hit way E -> no bus_req, rsp_hit=1.
5. Same-cycle bus_gnt and bus_done, plus bus_gnt delayed 10 cycles: bus_req is held throughout and drops one cycle after grant; FSM does not hang.
6. Reset and back-pressure: rst_n low during BUS_WAIT -> bus_req=0, req_ready=1, no rsp_valid. req_valid held during a busy period is accepted exactly once, after RESP.
